tl_byte_bridge: RTL and testbench
=================================

# tl_byte_bridge

Parametrised TileLink-UL slave that serialises A-channel requests into a byte-wide command FIFO and reassembles byte-wide response FIFO traffic into D-channel beats. Successor to the read-only ROM front end: generalised address/data width, adds PutFullData writes and a denied response for unsupported opcodes. Sits between the system bus and any byte-stream backend (ROM, flash, UART-attached memory model).

## Interface
- ADDR_W, 64, address width in bits; multiple of 8, ≥ 8
- DATA_W, 64, data width in bits; multiple of 8, ≥ 8
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- a_valid  in  1  request valid
- a_ready  out  1  request accepted when a_valid & a_ready
- a_opcode  in  3  4 = Get, 0 = PutFullData, others unsupported
- a_address  in  ADDR_W  byte address
- a_data  in  DATA_W  write data (Put only)
- d_valid  out  1  response valid
- d_ready  in  1  response consumed when d_valid & d_ready
- d_opcode  out  3  1 = AccessAckData, 0 = AccessAck
- d_denied  out  1  request not executed
- d_data  out  DATA_W  read data (valid with AccessAckData)
- almost_full  in  1  command FIFO cannot take a byte this cycle
- wr_en  out  1  push dout into command FIFO
- dout  out  8  command byte
- almost_empty  in  1  response FIFO has no readable byte this cycle
- rd_en  out  1  pop response FIFO; byte appears on din next cycle
- din  in  8  response byte

## Operation
- One transaction outstanding. States: IDLE, HDR, ADDR, DATA, RESP, RWAIT, DRESP.
- IDLE: a_ready = 1. On handshake register opcode/address/data. Supported opcode -> HDR; unsupported -> DRESP with d_denied = 1, d_opcode = 0, backend untouched.
- Command frame, little-endian: header byte {a_opcode, 5'b0}; then ADDR_W/8 address bytes; then DATA_W/8 data bytes for Put only.
- HDR/ADDR/DATA: a byte is pushed (wr_en = 1, dout = byte) only in cycles where almost_full = 0; otherwise hold byte and counter. After last byte -> RESP.
- Response frame: Get returns DATA_W/8 bytes LSB first; Put returns 1 status byte, bit 0 = 1 means denied.
- RESP: rd_en = 1 when almost_empty = 0 -> RWAIT. RWAIT: capture din into byte slot of d_data (or status); more bytes needed -> RESP (back-to-back rd_en allowed: RWAIT may issue next rd_en same cycle if almost_empty = 0), else -> DRESP.
- DRESP: d_valid = 1, outputs stable until d_ready; then -> IDLE. d_data zero for AccessAck and denied responses.
- Byte counter width $clog2(max(ADDR_W, DATA_W)/8 + 1); wraps only on state change, reset to 0 on every state entry.

## Timing
- Reset: a_ready = 0 during reset, 1 the first cycle after release; d_valid, wr_en, rd_en = 0; dout, d_data, d_opcode, d_denied = 0; state IDLE.
- wr_en, dout, rd_en, d_* registered outputs; a_ready combinational from state.
- Unstalled Get, ADDR_W = DATA_W = 64: accept cycle 0, 9 command bytes cycles 1–9, first rd_en cycle 10, 8 bytes read cycles 10–17, d_valid cycle 19.
- Put, 64/64: 17 command bytes, 1 response byte.
- almost_full/almost_empty sampled each cycle; stall inserts bubbles without dropping or duplicating bytes.
- d_ready high in the d_valid cycle: next request accepted the following cycle (IDLE).
- rst_n assertion mid-transaction: immediate return to reset values; partially sent frame abandoned (backend resets with the same rst_n).

## Structure
- Shared package tl_pkg: opcode constants (TL_GET, TL_PUT_FULL, TL_ACK, TL_ACK_DATA), state enum, header-byte layout.
- Optional sub-module tl_byte_shifter: N-byte shift/collect register with counter, instanced once for command serialisation and once for response assembly.

## Test plan
- Get addr 0x1000, backend returns bytes 0x01..0x08 -> dout 0x80,00,10,00,00,00,00,00,00; d_opcode 1, d_data 0x0807060504030201, d_valid cycle 19.
- Put addr 0x20 data 0xDEADBEEFCAFEF00D, status 0x00 -> 17 command bytes ending 0x0D,0xF0,0xFE,0xCA,0xEF,0xBE,0xAD,0xDE; d_opcode 0, d_denied 0.
- almost_full toggled every other cycle during Get -> identical 9-byte sequence, no duplicates; same for almost_empty on response.
- a_opcode 2 -> no wr_en, d_valid within 2 cycles with d_denied 1; Put with status 0x01 -> d_denied 1.
- d_ready held low 5 cycles -> d_valid, d_data stable; a_ready 0 throughout.
- rst_n pulsed after 4th command byte -> all outputs reset values; following Get completes correctly.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared TileLink-UL opcodes, bridge state encoding and command-header layout.
package tl_pkg;

    localparam logic [2:0] TL_GET      = 3'd4;
    localparam logic [2:0] TL_PUT_FULL = 3'd0;
    localparam logic [2:0] TL_ACK      = 3'd0;
    localparam logic [2:0] TL_ACK_DATA = 3'd1;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_HDR   = 3'd1;
    localparam logic [STATE_W-1:0] ST_ADDR  = 3'd2;
    localparam logic [STATE_W-1:0] ST_DATA  = 3'd3;
    localparam logic [STATE_W-1:0] ST_RESP  = 3'd4;
    localparam logic [STATE_W-1:0] ST_RWAIT = 3'd5;
    localparam logic [STATE_W-1:0] ST_DRESP = 3'd6;

    // Header byte carries the opcode in its top three bits.
    function automatic logic [7:0] hdr_byte(input logic [2:0] op);
        return {op, 5'b0_0000};
    endfunction

    function automatic logic op_supported(input logic [2:0] op);
        return (op == TL_GET) || (op == TL_PUT_FULL);
    endfunction

endpackage

// File: rtl/tl_byte_bridge.sv
// TileLink-UL slave bridging single A/D transactions onto byte-wide command
// and response FIFOs; one transaction outstanding at a time.
module tl_byte_bridge
    import tl_pkg::*;
#(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [2:0]        a_opcode,
    input  logic [ADDR_W-1:0] a_address,
    input  logic [DATA_W-1:0] a_data,
    output logic              d_valid,
    input  logic              d_ready,
    output logic [2:0]        d_opcode,
    output logic              d_denied,
    output logic [DATA_W-1:0] d_data,
    input  logic              almost_full,
    output logic              wr_en,
    output logic [7:0]        dout,
    input  logic              almost_empty,
    output logic              rd_en,
    input  logic [7:0]        din
);

    localparam int unsigned AB    = ADDR_W / 8;
    localparam int unsigned DB    = DATA_W / 8;
    localparam int unsigned MAXB  = (AB > DB) ? AB : DB;
    localparam int unsigned CNT_W = $clog2(MAXB + 1);

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(AB - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DB - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   ccnt_q, ccnt_d;
    logic [2:0]         op_q, op_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               wr_en_q, wr_en_d;
    logic [7:0]         dout_q, dout_d;
    logic               rd_en_q, rd_en_d;
    logic               pend_q;
    logic               d_valid_q, d_valid_d;
    logic [2:0]         d_opcode_q, d_opcode_d;
    logic               d_denied_q, d_denied_d;
    logic               is_put_c;
    logic [CNT_W-1:0]   resp_last_c;

    assign is_put_c    = (op_q == TL_PUT_FULL);
    assign resp_last_c = is_put_c ? '0 : DATA_LAST;

    // Next-state and registered-output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ccnt_d     = ccnt_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        wr_en_d    = 1'b0;
        dout_d     = dout_q;
        rd_en_d    = 1'b0;
        d_valid_d  = d_valid_q;
        d_opcode_d = d_opcode_q;
        d_denied_d = d_denied_q;

        // A pop issued last cycle presents its byte on din now.
        if (pend_q) begin
            if (!is_put_c) begin
                rdata_d[int'(ccnt_q)*8 +: 8] = din;
            end
            ccnt_d = ccnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (a_valid) begin
                    op_d    = a_opcode;
                    addr_d  = a_address;
                    wdata_d = a_data;
                    rdata_d = '0;
                    cnt_d   = '0;
                    ccnt_d  = '0;
                    if (op_supported(a_opcode)) begin
                        if (!almost_full) begin
                            wr_en_d = 1'b1;
                            dout_d  = hdr_byte(a_opcode);
                            state_d = ST_ADDR;
                        end else begin
                            state_d = ST_HDR;
                        end
                    end else begin
                        state_d    = ST_DRESP;
                        d_valid_d  = 1'b1;
                        d_opcode_d = TL_ACK;
                        d_denied_d = 1'b1;
                    end
                end
            end
            ST_HDR: begin
                if (!almost_full) begin
                    wr_en_d = 1'b1;
                    dout_d  = hdr_byte(op_q);
                    cnt_d   = '0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (!almost_full) begin
                    wr_en_d = 1'b1;
                    dout_d  = addr_q[int'(cnt_q)*8 +: 8];
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d   = '0;
                        state_d = is_put_c ? ST_DATA : ST_RESP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (!almost_full) begin
                    wr_en_d = 1'b1;
                    dout_d  = wdata_q[int'(cnt_q)*8 +: 8];
                    if (cnt_q == DATA_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_RESP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_RESP: begin
                if (!almost_empty) begin
                    rd_en_d = 1'b1;
                    if (cnt_q == resp_last_c) begin
                        cnt_d   = '0;
                        state_d = ST_RWAIT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_RWAIT: begin
                if (pend_q && (ccnt_q == resp_last_c)) begin
                    state_d    = ST_DRESP;
                    d_valid_d  = 1'b1;
                    d_opcode_d = is_put_c ? TL_ACK : TL_ACK_DATA;
                    d_denied_d = is_put_c & din[0];
                end
            end
            ST_DRESP: begin
                if (d_ready) begin
                    d_valid_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ccnt_q     <= '0;
            op_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            wr_en_q    <= 1'b0;
            dout_q     <= '0;
            rd_en_q    <= 1'b0;
            pend_q     <= 1'b0;
            d_valid_q  <= 1'b0;
            d_opcode_q <= '0;
            d_denied_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ccnt_q     <= ccnt_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            wr_en_q    <= wr_en_d;
            dout_q     <= dout_d;
            rd_en_q    <= rd_en_d;
            pend_q     <= rd_en_q;
            d_valid_q  <= d_valid_d;
            d_opcode_q <= d_opcode_d;
            d_denied_q <= d_denied_d;
        end
    end

    // Ready only out of reset and between transactions.
    assign a_ready  = rst_n & (state_q == ST_IDLE);
    assign wr_en    = wr_en_q;
    assign dout     = dout_q;
    assign rd_en    = rd_en_q;
    assign d_valid  = d_valid_q;
    assign d_opcode = d_opcode_q;
    assign d_denied = d_denied_q;
    assign d_data   = rdata_q;

endmodule

// File: tb/tb_tl_byte_bridge.sv
// Randomised self-checking bench for tl_byte_bridge with a frame-level model
// of the command/response byte streams and the expected D-channel beat.
module tb_tl_byte_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        a_valid, a_ready;
    logic [2:0]  a_opcode;
    logic [63:0] a_address, a_data;
    logic        d_valid, d_ready;
    logic [2:0]  d_opcode;
    logic        d_denied;
    logic [63:0] d_data;
    logic        almost_full, wr_en;
    logic [7:0]  dout;
    logic        almost_empty, rd_en;
    logic [7:0]  din;

    tl_byte_bridge #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode),
        .a_address(a_address), .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode),
        .d_denied(d_denied), .d_data(d_data),
        .almost_full(almost_full), .wr_en(wr_en), .dout(dout),
        .almost_empty(almost_empty), .rd_en(rd_en), .din(din)
    );

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    logic [7:0]  exp_cmd[$];
    logic [7:0]  cmd_log[$];
    logic [7:0]  resp_q[$];
    int          pops_left = 0;
    logic [2:0]  exp_dop;
    logic        exp_den;
    logic [63:0] exp_dd;
    bit          busy = 0, acc_seen = 0, dv_seen = 0, pop_pend = 0;
    int          acc_cyc = 0, dv_cyc = 0;
    logic [63:0] last_dd;
    logic [2:0]  last_dop;
    logic        last_den;
    int          af_mode = 0, ae_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic stall_bit(input int mode);
        if (mode == 1) return cyc[0];
        if (mode == 2) return ($urandom % 3) == 0;
        return 1'b0;
    endfunction

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    // Backend side: stall flags and response bytes one cycle after each pop.
    initial begin
        almost_full = 1'b0; almost_empty = 1'b0; din = 8'h00;
        forever begin
            @(posedge clk); #1;
            almost_full  = stall_bit(af_mode);
            almost_empty = stall_bit(ae_mode);
            if (pop_pend && resp_q.size() > 0) din = resp_q.pop_front();
        end
    end

    // Compare process: every cycle against the frame-level model.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            exp_cmd.delete(); resp_q.delete();
            pops_left = 0; busy = 0; pop_pend = 0;
        end else begin
            check("a_ready", a_ready, !busy);
            if (wr_en) begin
                cmd_log.push_back(dout);
                check("wr_en_expected", exp_cmd.size() != 0, 1);
                if (exp_cmd.size() != 0) check("dout", dout, exp_cmd.pop_front());
            end
            pop_pend = rd_en;
            if (rd_en) begin
                check("rd_en_expected", pops_left != 0, 1);
                if (pops_left != 0) pops_left--;
            end
            if (d_valid) begin
                check("d_valid_expected", busy, 1);
                if (busy && !dv_seen) begin
                    dv_seen = 1; dv_cyc = cyc;
                    last_dd = d_data; last_dop = d_opcode; last_den = d_denied;
                    check("cmd_bytes_left", exp_cmd.size(), 0);
                    check("pops_left", pops_left, 0);
                end
                check("d_opcode", d_opcode, exp_dop);
                check("d_denied", d_denied, exp_den);
                check("d_data", d_data, exp_dd);
            end
            if (a_valid && a_ready) begin busy = 1; acc_seen = 1; acc_cyc = cyc; end
            if (d_valid && d_ready) busy = 0;
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_a_ready"}, a_ready, 0);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_d_valid"}, d_valid, 0);
        check({tag, "_dout"}, dout, 0);
        check({tag, "_d_data"}, d_data, 0);
        check({tag, "_d_opcode"}, d_opcode, 0);
        check({tag, "_d_denied"}, d_denied, 0);
    endtask

    task automatic start_txn(input logic [2:0] op, input logic [63:0] addr,
                             input logic [63:0] wd, input logic [63:0] rv);
        bit get, put;
        get = (op == 3'd4);
        put = (op == 3'd0);
        exp_cmd.delete(); cmd_log.delete(); resp_q.delete();
        if (get || put) begin
            exp_cmd.push_back({op, 5'b0});
            for (int i = 0; i < 8; i++) exp_cmd.push_back(addr[8*i +: 8]);
            if (put) for (int i = 0; i < 8; i++) exp_cmd.push_back(wd[8*i +: 8]);
        end
        if (get) for (int i = 0; i < 8; i++) resp_q.push_back(rv[8*i +: 8]);
        if (put) resp_q.push_back(rv[7:0]);
        pops_left = get ? 8 : (put ? 1 : 0);
        exp_dop = get ? 3'd1 : 3'd0;
        exp_den = !(get || put) || (put && rv[0]);
        exp_dd  = get ? rv : 64'h0;
        acc_seen = 0; dv_seen = 0;
        @(posedge clk); #1;
        a_valid = 1'b1; a_opcode = op; a_address = addr; a_data = wd;
        for (int i = 0; i < 50 && !acc_seen; i++) @(posedge clk);
        #1 a_valid = 1'b0;
        check("accepted", acc_seen, 1);
    endtask

    task automatic finish_txn(input int hold, output int lat);
        lat = -1;
        for (int i = 0; i < 3000 && !dv_seen; i++) @(posedge clk);
        check("response_seen", dv_seen, 1);
        if (dv_seen) begin
            repeat (hold) @(posedge clk);
            #1 d_ready = 1'b1;
            @(posedge clk);
            #1 d_ready = 1'b0;
            lat = dv_cyc - acc_cyc;
        end
    endtask

    task automatic run_txn(input logic [2:0] op, input logic [63:0] addr, input logic [63:0] wd,
                           input logic [63:0] rv, input int hold, output int lat);
        start_txn(op, addr, wd, rv);
        finish_txn(hold, lat);
    endtask

    logic [7:0] get_frame [9];
    logic [7:0] put_tail [8];
    int lat;

    initial begin
        get_frame = '{8'h80, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        put_tail  = '{8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        a_valid = 0; a_opcode = 0; a_address = 0; a_data = 0; d_ready = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // Unstalled Get pinned against literal frame, data and latency.
        run_txn(3'd4, 64'h1000, 64'h0, 64'h0807060504030201, 0, lat);
        check("get_latency", lat, 19);
        check("get_frame_len", cmd_log.size(), 9);
        for (int i = 0; i < 9 && i < cmd_log.size(); i++) check("get_frame_byte", cmd_log[i], get_frame[i]);
        check("get_d_data", last_dd, 64'h0807060504030201);
        check("get_d_opcode", last_dop, 1);

        // Put with d_ready held off for 5 cycles.
        run_txn(3'd0, 64'h20, 64'hDEADBEEFCAFEF00D, 64'h0, 5, lat);
        check("put_frame_len", cmd_log.size(), 17);
        for (int i = 0; i < 8 && cmd_log.size() == 17; i++) check("put_tail_byte", cmd_log[9+i], put_tail[i]);
        check("put_d_opcode", last_dop, 0);
        check("put_d_denied", last_den, 0);

        // Stalls on both FIFOs every other cycle.
        af_mode = 1; ae_mode = 1;
        run_txn(3'd4, 64'h1000, 64'h0, 64'h0807060504030201, 1, lat);
        check("stall_frame_len", cmd_log.size(), 9);
        for (int i = 0; i < 9 && i < cmd_log.size(); i++) check("stall_frame_byte", cmd_log[i], get_frame[i]);
        check("stall_d_data", last_dd, 64'h0807060504030201);
        af_mode = 0; ae_mode = 0;

        // Unsupported opcode and denied Put status.
        run_txn(3'd2, 64'h44, 64'h0, 64'h0, 0, lat);
        check("bad_op_no_cmd", cmd_log.size(), 0);
        check("bad_op_latency_le2", (lat >= 1) && (lat <= 2), 1);
        check("bad_op_denied", last_den, 1);
        run_txn(3'd0, 64'h88, 64'h1234, 64'h01, 0, lat);
        check("put_status_denied", last_den, 1);

        // Reset after the 4th command byte, then a clean Get.
        start_txn(3'd4, 64'h1000, 64'h0, 64'h0807060504030201);
        for (int i = 0; i < 100 && cmd_log.size() < 4; i++) @(posedge clk);
        check("four_bytes_before_reset", cmd_log.size() >= 4, 1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals("midreset");
        @(posedge clk); #1 rst_n = 1'b1;
        run_txn(3'd4, 64'h1000, 64'h0, 64'h0807060504030201, 0, lat);
        check("post_reset_d_data", last_dd, 64'h0807060504030201);
        check("post_reset_latency", lat, 19);

        // Randomised traffic.
        for (int t = 0; t < 40; t++) begin
            logic [2:0] o;
            int r;
            r = int'($urandom % 8);
            o = 3'($urandom);
            if (r < 3) o = 3'd4;
            else if (r < 6) o = 3'd0;
            else if (o == 3'd0 || o == 3'd4) o = 3'd2;
            af_mode = int'($urandom % 3);
            ae_mode = int'($urandom % 3);
            run_txn(o, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                    int'($urandom % 4), lat);
        end
        af_mode = 0; ae_mode = 0;
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
